// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin shared prescaled delay timer
module timer_sched #(
    parameter int NREQ       = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int PSCR_WIDTH = 20,
    parameter int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [PSCR_WIDTH-1:0]     pscr_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*CNT_WIDTH-1:0] req_dly_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic                      abort_i,
    output logic [NREQ-1:0]           done_o,
    output logic [NREQ-1:0]           aborted_o,
    output logic                      busy_o,
    output logic [OW-1:0]             owner_o,
    output logic [CNT_WIDTH-1:0]      cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          ptr_q, ptr_nxt;
    logic [OW-1:0]          owner_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [PSCR_WIDTH-1:0]  pscr_q;
    logic [PSCR_WIDTH-1:0]  pcnt_q;
    logic [NREQ-1:0]        aborted_q;
    logic [OW-1:0]          winner;
    logic                   found;
    logic                   accept;
    logic                   tick;
    logic [CNT_WIDTH-1:0]   dly_arr [NREQ];
    logic [NREQ-1:0]        owner_onehot;

    // Split the flat delay bus into one slice per requester
    for (genvar g = 0; g < NREQ; g++) begin : g_dly
        assign dly_arr[g] = req_dly_i[g*CNT_WIDTH +: CNT_WIDTH];
    end

    // Round-robin search starting at ptr; also the pointer value after a grant
    always_comb begin
        int idx;
        int nxt;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid_i[idx[OW-1:0]]) begin
                found  = 1'b1;
                winner = idx[OW-1:0];
            end
        end
        nxt = int'(winner) + 1;
        if (nxt >= NREQ) nxt = 0;
        ptr_nxt = nxt[OW-1:0];
    end

    assign accept       = (state_q == S_IDLE) && found;
    assign tick         = (state_q == S_RUN) && (pcnt_q == pscr_q);
    assign owner_onehot = NREQ'(1) << owner_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort outranks the final tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (dly_arr[winner] == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort_i)                              state_d = S_IDLE;
                else if (tick && cnt_q == CNT_WIDTH'(1))  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and latched owner
    always_comb begin
        req_ready_o = '0;
        done_o      = '0;
        busy_o      = (state_q != S_IDLE);
        if (accept)             req_ready_o = NREQ'(1) << winner;
        if (state_q == S_DONE)  done_o      = owner_onehot;
    end

    // Datapath: latch request on accept, prescale and count down while running
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            pscr_q    <= '0;
            pcnt_q    <= '0;
            aborted_q <= '0;
        end else begin
            aborted_q <= '0;
            if (accept) begin
                ptr_q   <= ptr_nxt;
                owner_q <= winner;
                cnt_q   <= dly_arr[winner];
                pscr_q  <= pscr_i;
                pcnt_q  <= '0;
            end else if (state_q == S_RUN) begin
                if (abort_i) begin
                    cnt_q     <= '0;
                    aborted_q <= owner_onehot;
                end else if (tick) begin
                    cnt_q  <= cnt_q - 1'b1;
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_q + 1'b1;
                end
            end
        end
    end

    assign aborted_o = aborted_q;
    assign owner_o   = owner_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed self-checking bench for timer_sched
module tb_timer_sched;

    localparam int NREQ = 4;
    localparam int CW   = 32;
    localparam int PW   = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PW-1:0]     pscr = '0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*CW-1:0] req_dly = '0;
    logic [NREQ-1:0]   req_ready;
    logic              abort = 1'b0;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   aborted;
    logic              busy;
    logic [1:0]        owner;
    logic [CW-1:0]     cnt;

    int errors = 0;
    int checks = 0;

    timer_sched #(.NREQ(NREQ), .CNT_WIDTH(CW), .PSCR_WIDTH(PW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pscr_i(pscr), .req_valid_i(req_valid),
        .req_dly_i(req_dly), .req_ready_o(req_ready), .abort_i(abort),
        .done_o(done), .aborted_o(aborted), .busy_o(busy), .owner_o(owner), .cnt_o(cnt)
    );

    always #5 clk = ~clk;

    // Advance to 2ns after the next rising edge; inputs are driven here
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dly(input int idx, input logic [CW-1:0] v);
        req_dly[idx*CW +: CW] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 4'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (aborted !== 4'b0) begin errors++; $display("FAIL reset_aborted got=%b exp=0000", aborted); end
        checks++; if (cnt !== 32'd0)   begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (owner !== 2'd0)  begin errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
    endtask

    // pscr=0, req 2, dly=3: busy from T+1, done only at T+4
    task automatic test_basic();
        pscr = 0; set_dly(2, 3); req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL basic_ready got=%b exp=0100", req_ready); end
        for (int k = 1; k <= 5; k++) begin
            next_cyc();
            req_valid = '0;
            #1;
            checks++; if (done !== ((k == 4) ? 4'b0100 : 4'b0000))
                begin errors++; $display("FAIL basic_done T+%0d got=%b", k, done); end
            checks++; if (busy !== (k <= 4))
                begin errors++; $display("FAIL basic_busy T+%0d got=%0b exp=%0b", k, busy, k <= 4); end
            checks++; if (k <= 4 && cnt !== 32'(4 - k))
                begin errors++; $display("FAIL basic_cnt T+%0d got=%0d exp=%0d", k, cnt, 4 - k); end
        end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL basic_owner got=%0d exp=2", owner); end
    endtask

    // pscr=4, dly=2: ticks at T+5 and T+10, done at T+11; later input changes ignored
    task automatic test_prescale();
        pscr = 4; set_dly(1, 2); req_valid = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            next_cyc();
            req_valid = '0; pscr = 0; set_dly(1, 7);
            #1;
            checks++; if (done !== ((k == 11) ? 4'b0010 : 4'b0000))
                begin errors++; $display("FAIL pscr_done T+%0d got=%b", k, done); end
            if (k == 5 || k == 6 || k == 10 || k == 11) begin
                checks++;
                if (cnt !== ((k == 5) ? 32'd2 : (k == 11) ? 32'd0 : 32'd1))
                    begin errors++; $display("FAIL pscr_cnt T+%0d got=%0d", k, cnt); end
            end
        end
    endtask

    // dly=0 goes straight to DONE
    task automatic test_zero_delay();
        pscr = 3; set_dly(0, 0); req_valid = 4'b0001;
        next_cyc();
        req_valid = '0;
        #1;
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL zero_done got=%b exp=0001", done); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL zero_busy got=%0b exp=1", busy); end
        next_cyc();
        #1;
        checks++; if (busy !== 1'b0 || done !== 4'b0)
            begin errors++; $display("FAIL zero_idle busy=%0b done=%b exp 0/0000", busy, done); end
    endtask

    // abort in IDLE does not block accept; abort on final tick wins
    task automatic test_abort_final();
        pscr = 0; set_dly(3, 2); req_valid = 4'b1000; abort = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL abort_idle_ready got=%b exp=1000", req_ready); end
        next_cyc();
        req_valid = '0; abort = 1'b0;
        next_cyc();
        abort = 1'b1;
        next_cyc();
        abort = 1'b0;
        #1;
        checks++; if (aborted !== 4'b1000) begin errors++; $display("FAIL abort_pulse got=%b exp=1000", aborted); end
        checks++; if (done !== 4'b0)       begin errors++; $display("FAIL abort_done got=%b exp=0000", done); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if (cnt !== 32'd0)       begin errors++; $display("FAIL abort_cnt got=%0d exp=0", cnt); end
        next_cyc();
        #1;
        checks++; if (aborted !== 4'b0 || done !== 4'b0)
            begin errors++; $display("FAIL abort_after aborted=%b done=%b exp 0000", aborted, done); end
    endtask

    // async reset mid-run clears everything; next grant goes to 0
    task automatic test_reset_mid_run();
        pscr = 0; set_dly(3, 5); req_valid = 4'b1000;
        next_cyc();
        req_valid = '0;
        next_cyc();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || cnt !== 32'd0 || owner !== 2'd0 || done !== 4'b0 || aborted !== 4'b0)
            begin errors++; $display("FAIL midrst_outs busy=%0b cnt=%0d owner=%0d done=%b aborted=%b exp all 0",
                                     busy, cnt, owner, done, aborted); end
        next_cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cyc();
            #1;
            checks++; if (done !== 4'b0 || aborted !== 4'b0)
                begin errors++; $display("FAIL midrst_silent k=%0d done=%b aborted=%b", k, done, aborted); end
        end
        req_valid = 4'b1111; set_dly(0, 1); set_dly(1, 1); set_dly(2, 1); set_dly(3, 1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant got=%b exp=0001", req_ready); end
    endtask

    // all valid, dly=1, pscr=0: grants 0,1,2,3,0 every third cycle
    task automatic test_round_robin();
        logic [NREQ-1:0] exp_ready;
        pscr = 0; req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_ready = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            checks++; if (req_ready !== exp_ready)
                begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            next_cyc();
        end
        req_valid = '0;
        next_cyc();
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_zero_delay();
        test_abort_final();
        test_reset_mid_run();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
